// File: rtl/mandelbrot_point_calc_if.sv
// rtl/mandelbrot_point_calc_if.sv - job request and result signals of the escape-time engine
interface mandelbrot_point_calc_if #(
    parameter int BIT_WIDTH = 32
);
    logic [BIT_WIDTH-1:0] real_part;
    logic [BIT_WIDTH-1:0] imaginary_part;
    logic                 start;
    logic                 out_ready;
    logic [BIT_WIDTH-1:0] colour_data;
    logic                 ready_for_input;

    modport master (
        output real_part,
        output imaginary_part,
        output start,
        input  out_ready,
        input  colour_data,
        input  ready_for_input
    );

    modport slave (
        input  real_part,
        input  imaginary_part,
        input  start,
        output out_ready,
        output colour_data,
        output ready_for_input
    );
endinterface

// File: rtl/mandelbrot_point_calc.sv
// rtl/mandelbrot_point_calc.sv - fixed-point Mandelbrot escape-time engine, one iteration per clock
module mandelbrot_point_calc #(
    parameter int BIT_WIDTH       = 32,
    parameter int MAX_ITERATIONS  = 512,
    parameter int FLOAT_PRECISION = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    mandelbrot_point_calc_if.slave bus
);
    localparam int ITER_W = $clog2(MAX_ITERATIONS + 1);
    localparam int PROD_W = 2 * BIT_WIDTH;
    localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(MAX_ITERATIONS);
    // 4.0 in the squared-magnitude scale; one extra bit so the sum of squares never wraps
    localparam logic signed [PROD_W:0] ESCAPE_LIMIT = (PROD_W + 1)'(4) << (2 * FLOAT_PRECISION);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t                      state;
    logic signed [BIT_WIDTH-1:0] zr, zi, cr, ci;
    logic [ITER_W-1:0]           iter;

    logic signed [PROD_W-1:0]    zr_w, zi_w, zr2, zi2, zri;
    logic signed [PROD_W:0]      mag;
    logic signed [BIT_WIDTH-1:0] zr_next, zi_next;
    logic                        escaped;

    always_comb begin
        zr_w    = {{BIT_WIDTH{zr[BIT_WIDTH-1]}}, zr};
        zi_w    = {{BIT_WIDTH{zi[BIT_WIDTH-1]}}, zi};
        zr2     = zr_w * zr_w;
        zi2     = zi_w * zi_w;
        zri     = zr_w * zi_w;
        mag     = {zr2[PROD_W-1], zr2} + {zi2[PROD_W-1], zi2};
        escaped = mag > ESCAPE_LIMIT;
        zr_next = BIT_WIDTH'((zr2 - zi2) >>> FLOAT_PRECISION) + cr;
        zi_next = BIT_WIDTH'((zri <<< 1) >>> FLOAT_PRECISION) + ci;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            zr                  <= '0;
            zi                  <= '0;
            cr                  <= '0;
            ci                  <= '0;
            iter                <= '0;
            bus.colour_data     <= '0;
            bus.out_ready       <= 1'b0;
            bus.ready_for_input <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    bus.out_ready <= 1'b0;
                    if (bus.start) begin
                        cr                  <= bus.real_part;
                        ci                  <= bus.imaginary_part;
                        zr                  <= '0;
                        zi                  <= '0;
                        iter                <= '0;
                        bus.ready_for_input <= 1'b0;
                        state               <= ITER;
                    end
                end
                ITER: begin
                    if (escaped || iter == ITER_CAP) begin
                        bus.colour_data <= BIT_WIDTH'(iter);
                        state           <= DONE;
                    end else begin
                        zr   <= zr_next;
                        zi   <= zi_next;
                        iter <= iter + 1'b1;
                    end
                end
                DONE: begin
                    bus.out_ready       <= 1'b1;
                    bus.ready_for_input <= 1'b1;
                    state               <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mandelbrot_point_calc.sv
// tb/tb_mandelbrot_point_calc.sv - randomized bench for mandelbrot_point_calc against an escape-time model
module tb_mandelbrot_point_calc;
    localparam int BW   = 32;
    localparam int MAXI = 512;
    localparam int FP   = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    mandelbrot_point_calc_if #(.BIT_WIDTH(BW)) bus ();

    mandelbrot_point_calc #(
        .BIT_WIDTH(BW),
        .MAX_ITERATIONS(MAXI),
        .FLOAT_PRECISION(FP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    int checks = 0;
    int passes = 0;

    // expected-behaviour state: at most one job in flight, result due on a known edge
    bit chk_en      = 1'b0;
    bit job_active  = 1'b0;
    int job_due     = 0;
    int job_colour  = 0;
    int last_colour = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    endtask

    function automatic int model_colour(input int cr, input int ci);
        int zr = 0;
        int zi = 0;
        longint zr2, zi2, zri;
        logic signed [64:0] mag;
        for (int n = 0; n <= MAXI; n++) begin
            zr2 = longint'(zr) * longint'(zr);
            zi2 = longint'(zi) * longint'(zi);
            zri = longint'(zr) * longint'(zi);
            mag = 65'(zr2) + 65'(zi2);
            if (mag > (65'sd4 <<< (2 * FP)) || n == MAXI) return n;
            zr = int'((zr2 - zi2) >>> FP) + cr;
            zi = int'((zri * 2) >>> FP) + ci;
        end
        return -1;
    endfunction

    function automatic int rand_c();
        if ($urandom_range(0, 7) == 0) return int'($urandom);
        return int'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000;
    endfunction

    // drives one clock of inputs; starts at posedge+2 and returns at the next posedge+2
    task automatic drive_cycle(input bit s, input int r, input int i, input bit do_rst);
        int e;
        bit acc;
        bus.start          = s;
        bus.real_part      = r;
        bus.imaginary_part = i;
        rst                = do_rst;
        e   = cyc + 1;
        acc = s && !do_rst && !(job_active && e <= job_due);
        @(posedge clk);
        #1;
        if (do_rst) begin
            job_active  = 1'b0;
            last_colour = 0;
        end else begin
            if (job_active && e > job_due) begin
                last_colour = job_colour;
                job_active  = 1'b0;
            end
            if (acc) begin
                job_active = 1'b1;
                job_colour = model_colour(r, i);
                job_due    = e + job_colour + 2;
            end
        end
        #1;
    endtask

    task automatic run_literal(input string name, input int r, input int i, input int want);
        int e;
        int lat = 0;
        bit seen = 1'b0;
        e = cyc + 1;
        drive_cycle(1'b1, r, i, 1'b0);
        for (int n = 0; n < MAXI + 10 && !seen; n++) begin
            drive_cycle(1'b0, int'($urandom), int'($urandom), 1'b0);
            if (bus.out_ready === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - e;
            end
        end
        chk({name, " result seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({name, " colour"}, 64'(bus.colour_data), 64'(want));
            chk({name, " latency"}, 64'(lat), 64'(want + 2));
        end
    endtask

    int  k_cmp;
    bit  busy_cmp, pulse_cmp;
    always @(negedge clk) begin
        if (chk_en) begin
            k_cmp     = cyc;
            busy_cmp  = job_active && k_cmp < job_due;
            pulse_cmp = job_active && k_cmp == job_due;
            chk("out_ready", 64'(bus.out_ready), 64'(pulse_cmp));
            chk("ready_for_input", 64'(bus.ready_for_input), 64'(!busy_cmp));
            if (!busy_cmp)
                chk("colour_data", 64'(bus.colour_data), 64'(job_active ? job_colour : last_colour));
        end
    end

    initial begin
        bus.start          = 1'b0;
        bus.real_part      = '0;
        bus.imaginary_part = '0;

        // the model itself, against hand-worked orbits
        chk("model c=0", 64'(model_colour(32'h0000_0000, 32'h0000_0000)), 64'd512);
        chk("model c=2", 64'(model_colour(32'h0200_0000, 32'h0000_0000)), 64'd2);
        chk("model c=1", 64'(model_colour(32'h0100_0000, 32'h0000_0000)), 64'd3);
        chk("model c=3", 64'(model_colour(32'h0300_0000, 32'h0000_0000)), 64'd1);
        chk("model c=-2", 64'(model_colour(32'hFE00_0000, 32'h0000_0000)), 64'd512);
        chk("model c=j", 64'(model_colour(32'h0000_0000, 32'h0100_0000)), 64'd512);
        chk("model c=-1+j", 64'(model_colour(32'hFF00_0000, 32'h0100_0000)), 64'd3);

        @(posedge clk);
        #2;
        drive_cycle(1'b1, 32'h0100_0000, 32'h0, 1'b1);
        drive_cycle(1'b1, 32'h0100_0000, 32'h0, 1'b1);
        chk("reset ready_for_input", 64'(bus.ready_for_input), 64'd1);
        chk("reset out_ready", 64'(bus.out_ready), 64'd0);
        chk("reset colour_data", 64'(bus.colour_data), 64'd0);
        chk_en = 1'b1;
        drive_cycle(1'b0, 0, 0, 1'b0);
        drive_cycle(1'b0, 0, 0, 1'b0);

        run_literal("c=0", 32'h0000_0000, 32'h0000_0000, 512);
        run_literal("c=2", 32'h0200_0000, 32'h0000_0000, 2);
        run_literal("c=1", 32'h0100_0000, 32'h0000_0000, 3);
        run_literal("c=3", 32'h0300_0000, 32'h0000_0000, 1);
        run_literal("c=-2", 32'hFE00_0000, 32'h0000_0000, 512);
        run_literal("c=j", 32'h0000_0000, 32'h0100_0000, 512);
        run_literal("c=-1+j", 32'hFF00_0000, 32'h0100_0000, 3);

        // start re-pulsed while busy must neither queue nor disturb the running job
        drive_cycle(1'b1, 32'h0, 32'h0, 1'b0);
        repeat (40) drive_cycle(1'b0, 0, 0, 1'b0);
        drive_cycle(1'b1, 32'h0300_0000, 32'h0, 1'b0);
        repeat (MAXI) drive_cycle(1'b0, 0, 0, 1'b0);
        chk("busy restart colour", 64'(bus.colour_data), 64'd512);

        // abort a job with reset
        drive_cycle(1'b1, 32'h0, 32'h0, 1'b0);
        repeat (100) drive_cycle(1'b0, 0, 0, 1'b0);
        drive_cycle(1'b0, 0, 0, 1'b1);
        chk("abort ready_for_input", 64'(bus.ready_for_input), 64'd1);
        chk("abort out_ready", 64'(bus.out_ready), 64'd0);
        repeat (MAXI + 10) drive_cycle(1'b0, 0, 0, 1'b0);
        run_literal("after abort c=3", 32'h0300_0000, 32'h0, 1);

        repeat (12000)
            drive_cycle($urandom_range(0, 3) == 0, rand_c(), rand_c(), $urandom_range(0, 2999) == 0);
        repeat (MAXI + 10) drive_cycle(1'b0, 0, 0, 1'b0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
